f1_reaction_timer: RTL
======================

// Module: f1_reaction_timer
// PURPOSE
//  Responder side of the F1 start-light sequence: measures the driver's reaction from lights-out to button press.
//  The light-sequencer FSM and clktick drive arm/lights_out/tick; this block samples the raw button and reports
//  reaction time in ms (binary), or flags a false start (press before lights-out) or timeout (no press).
//  Sits beside the light sequencer; its outputs feed the 7-seg/display path.
// PARAMETERS
//  CNT_W        16     width of reaction-time counter / time_ms
//  MAX_MS       9999   timeout limit in ticks; must be < 2**CNT_W
//  SYNC_STAGES  2      button synchroniser depth (>=2)
// PORTS
//  clk           in   1      system clock, all logic on posedge
//  rst_n         in   1      asynchronous active-low reset
//  arm           in   1      1-cycle pulse: light sequence started (new round)
//  lights_out    in   1      1-cycle pulse: all lights extinguished, timing starts
//  tick          in   1      1-cycle 1 ms enable from clktick
//  btn           in   1      raw, asynchronous driver button (active-high)
//  clr           in   1      synchronous abort/clear, highest priority after reset
//  time_ms       out  CNT_W  latched reaction time in ticks; valid when result_valid
//  result_valid  out  1      level: good result held in time_ms
//  false_start   out  1      level: press seen in ARMED
//  timeout       out  1      level: count reached MAX_MS without press
//  busy          out  1      high in ARMED or TIMING
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, counter=0, time_ms=0, all flags 0, synchroniser flops 0.
//  Button: SYNC_STAGES-flop sync, then rising-edge detect -> press (1-cycle). press is registered;
//   raw btn rise to press high = SYNC_STAGES+1 clk. Level held high yields exactly one press.
//  FSM states IDLE, ARMED, TIMING, DONE (all transitions on posedge; outputs registered):
//   IDLE  : arm -> ARMED (counter=0, flags cleared). press/lights_out/tick ignored.
//   ARMED : press -> DONE, false_start=1, time_ms=0.
//           lights_out (no press) -> TIMING, counter=0.
//           press and lights_out same cycle -> false start (press predates lights-out via sync delay).
//   TIMING: tick -> counter+1. press -> DONE, time_ms=counter (value BEFORE any same-cycle tick), result_valid=1.
//           counter==MAX_MS -> DONE, timeout=1, time_ms=MAX_MS; press in that same cycle wins (good result).
//           arm/lights_out ignored.
//   DONE  : outputs held. arm -> ARMED, flags/time_ms/counter cleared in that transition. press ignored.
//  clr (any state): next cycle IDLE, time_ms=0, flags 0, counter 0; overrides every other input.
//  Exactly one of result_valid/false_start/timeout may be high; all low outside DONE.
//  busy = (state==ARMED)|(state==TIMING), registered-state decode.
//  Counter never wraps: cannot exceed MAX_MS.
// STRUCTURE
//  Shared package f1_pkg: typedef enum logic [1:0] {RT_IDLE,RT_ARMED,RT_TIMING,RT_DONE} rt_state_t;
//   localparam default MAX_MS; CNT_W default shared with display path.
//  One sub-module: btn_sync_edge (SYNC_STAGES param; clk, rst_n, async_in -> rise_pulse).
//  Top: FSM next-state comb block, state/counter/result registers.
// TESTING (tick every 4 clk, SYNC_STAGES=2, MAX_MS=20 unless stated)
//  1 Good reaction: arm, lights_out, btn rises after 7 ticks -> result_valid=1, time_ms=7, busy=0,
//    press seen 3 clk after btn rise.
//  2 False start: arm, btn high before lights_out -> false_start=1, time_ms=0; later lights_out ignored, state DONE.
//  3 Timeout: arm, lights_out, no btn -> at counter==20 timeout=1, time_ms=20; late btn ignored.
//  4 Corners: press and lights_out same cycle -> false_start; press and tick same cycle at counter=5
//    -> time_ms=5; press at counter==MAX_MS -> result_valid, time_ms=20.
//  5 Button held high across two rounds -> one press only; round 2 needs release+re-press.
//  6 Reset/clear mid-TIMING: rst_n low async -> outputs 0 immediately; clr -> IDLE next clk;
//    arm in DONE starts a clean round with flags cleared.

Source files
------------

// File: rtl/f1_reaction_timer_pkg.sv
// f1_pkg: shared state encoding and default sizing for the F1 reaction timer and display path
package f1_pkg;
   typedef enum logic [1:0] {RT_IDLE, RT_ARMED, RT_TIMING, RT_DONE} rt_state_t;
   localparam int DEF_CNT_W  = 16;
   localparam int DEF_MAX_MS = 9999;
endpackage

// File: rtl/f1_reaction_timer_if.sv
// f1_reaction_timer_if: control pulses and button in, reaction result and status out
interface f1_reaction_timer_if import f1_pkg::*; #(parameter int CNT_W = DEF_CNT_W);
   logic             arm, lights_out, tick, btn, clr;
   logic [CNT_W-1:0] time_ms;
   logic             result_valid, false_start, timeout, busy;
   modport master (output arm, lights_out, tick, btn, clr,
                   input  time_ms, result_valid, false_start, timeout, busy);
   modport slave  (input  arm, lights_out, tick, btn, clr,
                   output time_ms, result_valid, false_start, timeout, busy);
endinterface

// File: rtl/f1_reaction_timer_btn_sync_edge.sv
// btn_sync_edge: synchronises an async level and emits a registered one-cycle pulse on its rising edge
module btn_sync_edge #(parameter int SYNC_STAGES = 2) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise_pulse
);
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync       <= '0;
         prev       <= 1'b0;
         rise_pulse <= 1'b0;
      end else begin
         sync       <= {sync[SYNC_STAGES-2:0], async_in};
         prev       <= sync[SYNC_STAGES-1];
         rise_pulse <= sync[SYNC_STAGES-1] & ~prev;
      end
   end
endmodule

// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: times lights-out to button press, flagging false starts and timeouts
module f1_reaction_timer import f1_pkg::*; #(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int MAX_MS      = DEF_MAX_MS,
   parameter int SYNC_STAGES = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   f1_reaction_timer_if.slave  bus
);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_MS);
   rt_state_t        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, time_n;
   logic             press, wipe, rv_n, fs_n, to_n;
   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
      .clk(clk), .rst_n(rst_n), .async_in(bus.btn), .rise_pulse(press)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= RT_IDLE;
         cnt              <= '0;
         bus.time_ms      <= '0;
         bus.result_valid <= 1'b0;
         bus.false_start  <= 1'b0;
         bus.timeout      <= 1'b0;
      end else begin
         state            <= state_n;
         cnt              <= cnt_n;
         bus.time_ms      <= time_n;
         bus.result_valid <= rv_n;
         bus.false_start  <= fs_n;
         bus.timeout      <= to_n;
      end
   end
   // clr, or arm from IDLE/DONE, wipes the round; only ARMED/TIMING then see press/lights_out/tick
   always_comb begin
      wipe    = bus.clr | (bus.arm & ((state == RT_IDLE) | (state == RT_DONE)));
      state_n = bus.clr ? RT_IDLE : wipe ? RT_ARMED : state;
      cnt_n   = wipe ? '0 : cnt;
      time_n  = wipe ? '0 : bus.time_ms;
      rv_n    = ~wipe & bus.result_valid;
      fs_n    = ~wipe & bus.false_start;
      to_n    = ~wipe & bus.timeout;
      if (!wipe && state == RT_ARMED) begin
         if (press) begin
            state_n = RT_DONE;
            fs_n    = 1'b1;
         end else if (bus.lights_out) begin
            state_n = RT_TIMING;
            cnt_n   = '0;
         end
      end else if (!wipe && state == RT_TIMING) begin
         if (press) begin
            state_n = RT_DONE;
            time_n  = cnt;
            rv_n    = 1'b1;
         end else if (cnt == LIMIT) begin
            state_n = RT_DONE;
            time_n  = LIMIT;
            to_n    = 1'b1;
         end else if (bus.tick) begin
            cnt_n   = cnt + 1'b1;
         end
      end
   end
   assign bus.busy = (state == RT_ARMED) | (state == RT_TIMING);
endmodule
